// File: rtl/key_event_conditioner.sv
// Push-button conditioner: sync, debounce, edge pulse, priority arbiter.
// Optional auto-repeat on up/down keys under `ifdef KEY_AUTO_REPEAT_EN.
module key_event_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd6000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd1500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_key_n,
  output logic       o_select,
  output logic       o_back,
  output logic       o_up,
  output logic       o_down,
  output logic [3:0] o_held,
  output logic       o_drop
);

  localparam logic [1:0] REL       = 2'd0;
  localparam logic [1:0] PRESS_CHK = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CHK   = 2'd3;

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] s_key;
  logic [3:0] press_evt;
  logic [3:0] rpt_evt;
  logic [3:0] evt;
  logic [3:0] win;
  logic       drop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= i_key_n;
      sync2 <= sync1;
    end
  end

  assign s_key = ~sync2;

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [1:0]  st;
    logic [15:0] cnt;

    assign press_evt[k] = (st == PRESS_CHK) && s_key[k] &&
                          (cnt == DEBOUNCE_CYCLES);
    // HELD and REL_CHK both have st[1] set
    assign o_held[k] = st[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        st  <= REL;
        cnt <= 16'd0;
      end else begin
        unique case (st)
          REL: begin
            if (s_key[k]) begin
              st  <= PRESS_CHK;
              cnt <= 16'd1;
            end else begin
              cnt <= 16'd0;
            end
          end
          PRESS_CHK: begin
            if (!s_key[k]) begin
              st  <= REL;
              cnt <= 16'd0;
            end else if (cnt == DEBOUNCE_CYCLES) begin
              st  <= HELD;
              cnt <= 16'd0;
            end else if (cnt != 16'hFFFF) begin
              cnt <= cnt + 16'd1;
            end
          end
          HELD: begin
            if (!s_key[k]) begin
              st  <= REL_CHK;
              cnt <= 16'd1;
            end
          end
          REL_CHK: begin
            if (s_key[k]) begin
              st  <= HELD;
              cnt <= 16'd0;
            end else if (cnt == DEBOUNCE_CYCLES) begin
              st  <= REL;
              cnt <= 16'd0;
            end else if (cnt != 16'hFFFF) begin
              cnt <= cnt + 16'd1;
            end
          end
        endcase
      end
    end

`ifdef KEY_AUTO_REPEAT_EN
    if (k < 2) begin : g_rpt
      logic [23:0] rcnt;
      logic        first;
      logic [23:0] limit;

      assign limit      = first ? REPEAT_DELAY : REPEAT_PERIOD;
      assign rpt_evt[k] = st[1] && (rcnt == limit);

      // Timer keeps running through a REL_CHK bounce back to HELD
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          rcnt  <= 24'd0;
          first <= 1'b1;
        end else if (st[1]) begin
          if (rcnt == limit) begin
            rcnt  <= 24'd1;
            first <= 1'b0;
          end else if (rcnt != 24'hFFFFFF) begin
            rcnt <= rcnt + 24'd1;
          end
        end else begin
          rcnt  <= press_evt[k] ? 24'd1 : 24'd0;
          first <= 1'b1;
        end
      end
    end else begin : g_norpt
      assign rpt_evt[k] = 1'b0;
    end
`else
    assign rpt_evt[k] = 1'b0;
`endif
  end

`ifndef KEY_AUTO_REPEAT_EN
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  assign evt  = press_evt | rpt_evt;
  assign drop = |(evt & (evt - 4'd1));

  // back > select > up > down
  always_comb begin
    win = 4'b0000;
    priority case (1'b1)
      evt[2]:  win[2] = 1'b1;
      evt[3]:  win[3] = 1'b1;
      evt[1]:  win[1] = 1'b1;
      evt[0]:  win[0] = 1'b1;
      default: win = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_select <= 1'b0;
      o_back   <= 1'b0;
      o_up     <= 1'b0;
      o_down   <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      o_select <= win[3];
      o_back   <= win[2];
      o_up     <= win[1];
      o_down   <= win[0];
      o_drop   <= drop;
    end
  end

endmodule

// File: tb/tb_key_event_conditioner.sv
// Scoreboard bench for key_event_conditioner (small debounce/repeat timing).
// Honours KEY_AUTO_REPEAT_EN to match the DUT build.
module tb_key_event_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  localparam logic [4:0] SEL  = 5'b10000;
  localparam logic [4:0] BACK = 5'b01000;
  localparam logic [4:0] UP   = 5'b00100;
  localparam logic [4:0] DROP = 5'b00001;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_key_n;
  logic       o_select;
  logic       o_back;
  logic       o_up;
  logic       o_down;
  logic [3:0] o_held;
  logic       o_drop;

  key_event_conditioner #(
    .DEBOUNCE_CYCLES(16'(D)),
    .REPEAT_DELAY   (24'(RD)),
    .REPEAT_PERIOD  (24'(RP))
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_key_n (i_key_n),
    .o_select(o_select),
    .o_back  (o_back),
    .o_up    (o_up),
    .o_down  (o_down),
    .o_held  (o_held),
    .o_drop  (o_drop)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [4:0] v;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic [4:0] obs;
  int vecs = 0;
  int errs = 0;

  always @(negedge i_clk) begin
    obs = {o_select, o_back, o_up, o_down, o_drop};
    if (obs != 5'b0) begin
      vecs++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL pulse_unexpected cyc=%0d got=%b want=none",
                 cyc, obs);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.c != cyc || mon_e.v !== obs) begin
          errs++;
          $display("FAIL pulse cyc=%0d got=%b want=%b@%0d",
                   cyc, obs, mon_e.v, mon_e.c);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].c < cyc) begin
      mon_e = sbq.pop_front();
      vecs++;
      errs++;
      $display("FAIL pulse_missing cyc=%0d got=none want=%b@%0d",
               cyc, mon_e.v, mon_e.c);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic expect_ev(input int c, input logic [4:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sbq.size() > 0; i++) tick(1);
    vecs++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain_%s got=%0d pending want=0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    i_key_n = 4'hF;
    tick(3);
    vecs++;
    if ({o_select, o_back, o_up, o_down, o_drop, o_held} !== 9'b0) begin
      errs++;
      $display("FAIL reset_outputs got=%b want=0",
               {o_select, o_back, o_up, o_down, o_drop, o_held});
    end
    i_rst = 1'b0;
    tick(3);
    vecs++;
    if ({o_select, o_back, o_up, o_down, o_drop, o_held} !== 9'b0) begin
      errs++;
      $display("FAIL post_reset_idle got=%b want=0",
               {o_select, o_back, o_up, o_down, o_drop, o_held});
    end
  endtask

  task automatic test_clean_press;
    int d;
    d = cyc;
    i_key_n[1] = 1'b0;
    expect_ev(d + 7, UP);
    tick(6);
    vecs++;
    if (o_held !== 4'b0000) begin
      errs++;
      $display("FAIL held_before_debounce got=%b want=0000", o_held);
    end
    tick(1);
    vecs++;
    if (o_held !== 4'b0010) begin
      errs++;
      $display("FAIL held_after_debounce got=%b want=0010", o_held);
    end
    tick(3);
    i_key_n = 4'hF;
    tick(10);
    vecs++;
    if (o_held !== 4'b0000) begin
      errs++;
      $display("FAIL held_after_release got=%b want=0000", o_held);
    end
    drain("clean");
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 30; i++) begin
      i_key_n[0] = ((i % 4) < 2) ? 1'b0 : 1'b1;
      tick(1);
      vecs++;
      if (o_held[0] !== 1'b0) begin
        errs++;
        $display("FAIL bounce_held i=%0d got=%b want=0", i, o_held[0]);
      end
    end
    i_key_n[0] = 1'b1;
    tick(10);
    drain("bounce");
  endtask

  task automatic test_simultaneous;
    int d;
    d = cyc;
    i_key_n[3:2] = 2'b00;
    expect_ev(d + 7, BACK | DROP);
    tick(8);
    vecs++;
    if (o_held !== 4'b1100) begin
      errs++;
      $display("FAIL simul_held got=%b want=1100", o_held);
    end
    tick(4);
    i_key_n = 4'hF;
    tick(10);
    drain("simul");
  endtask

  task automatic test_auto_repeat;
    int d;
    d = cyc;
    i_key_n[1] = 1'b0;
    expect_ev(d + 7, UP);
`ifdef KEY_AUTO_REPEAT_EN
    begin
      int r;
      r = d + 59;
      for (int t = d + 7 + RD; t <= r + 2 + D; t += RP)
        expect_ev(t, UP);
    end
`endif
    tick(58);
    i_key_n[1] = 1'b1;
    tick(12);
    drain("repeat");
  endtask

  task automatic test_glitch;
    int d;
    d = cyc;
    i_key_n[2] = 1'b0;
    expect_ev(d + 7, BACK);
    tick(8);
    for (int i = 0; i < 50; i++) begin
      if (i == 32) i_key_n[2] = 1'b1;
      if (i == 34) i_key_n[2] = 1'b0;
      tick(1);
      vecs++;
      if (o_held !== 4'b0100) begin
        errs++;
        $display("FAIL glitch_held i=%0d got=%b want=0100", i, o_held);
      end
    end
    i_key_n = 4'hF;
    tick(12);
    drain("glitch");
  endtask

  task automatic test_reset_mid;
    int d;
    int k;
    d = cyc;
    i_key_n[1] = 1'b0;
    expect_ev(d + 7, UP);
    tick(8);
    i_rst = 1'b1;
    #1;
    vecs++;
    if ({o_select, o_back, o_up, o_down, o_drop, o_held} !== 9'b0) begin
      errs++;
      $display("FAIL async_reset_clear got=%b want=0",
               {o_select, o_back, o_up, o_down, o_drop, o_held});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vecs++;
      if ({o_up, o_held} !== 5'b0) begin
        errs++;
        $display("FAIL in_reset i=%0d got=%b want=0", i, {o_up, o_held});
      end
    end
    i_rst = 1'b0;
    k = cyc;
    expect_ev(k + 7, UP);
    tick(5);
    vecs++;
    if (o_held !== 4'b0000) begin
      errs++;
      $display("FAIL reset_rehold_early got=%b want=0000", o_held);
    end
    tick(5);
    vecs++;
    if (o_held !== 4'b0010) begin
      errs++;
      $display("FAIL reset_rehold got=%b want=0010", o_held);
    end
    i_key_n = 4'hF;
    tick(12);
    drain("reset_mid");
  endtask

  initial begin
    i_rst = 1'b1;
    i_key_n = 4'hF;
    test_reset;
    test_clean_press;
    test_bounce;
    test_simultaneous;
    test_auto_repeat;
    test_glitch;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
